// File: rtl/req_arbiter.sv
// Round-robin request arbiter: two-state FSM, registered one-hot grant, one idle cycle between grants.
// Define ARB_TIMEOUT_EN to revoke a grant that is held for TIMEOUT cycles without release.
module req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       gnt_valid,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       timeout
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [7:0]     cnt;
    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic           rel;
    logic           expire;
    logic [IDW-1:0] next_ptr;

    // First set request bit at or above p, wrapping; MSB of result flags a hit.
    function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDW-1:0]     p);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NUM_REQ;
            if (r[idx]) res = {1'b1, IDW'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gnt_id = IDW'(i);
        end
    end

    assign gnt_valid             = |gnt;
    assign {pick_found, pick_idx} = rr_pick(req, ptr);
    assign rel                   = |(gnt & (done | ~req));
    assign expire                = TMO_EN && (cnt == CNT_LAST);
    assign next_ptr              = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            ptr     <= '0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // A genuine release wins over an expiry landing on the same cycle.
                    if (rel || expire) begin
                        gnt     <= '0;
                        ptr     <= next_ptr;
                        timeout <= expire && !rel;
                        state   <= IDLE;
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_arbiter.sv
// Directed bench for req_arbiter: per-cycle vector table plus reset and timeout sequences.
module tb_req_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    req_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                           input logic t);
        chk({tag, ".gnt"},       8'(gnt),       8'(g));
        chk({tag, ".gnt_valid"}, 8'(gnt_valid), 8'(g != 4'b0000));
        chk({tag, ".gnt_id"},    8'(gnt_id),    8'(id));
        chk({tag, ".timeout"},   8'(timeout),   8'(t));
    endtask

    initial begin
        int hi;
        int tcount;

        //                 req      done     gnt      id  tmo
        vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0}); // idle stays idle
        vecs.push_back('{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0}); // single requester
        vecs.push_back('{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0});
        vecs.push_back('{4'b0100, 4'b0100, 4'b0000, 2'd0, 1'b0}); // done -> ptr 3
        vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0});
        vecs.push_back('{4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0}); // wrap from ptr 3
        vecs.push_back('{4'b0011, 4'b0001, 4'b0000, 2'd0, 1'b0}); // ptr 1
        vecs.push_back('{4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0});
        vecs.push_back('{4'b1010, 4'b1101, 4'b0010, 2'd1, 1'b0}); // other bits ignored
        vecs.push_back('{4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0}); // req[1] drops -> ptr 2
        vecs.push_back('{4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b0}); // ptr 2 picks 3
        vecs.push_back('{4'b1001, 4'b1000, 4'b0000, 2'd0, 1'b0}); // done with req held
        vecs.push_back('{4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b0}); // rotation to 0 first
        vecs.push_back('{4'b1001, 4'b0001, 4'b0000, 2'd0, 1'b0});
        vecs.push_back('{4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b0});
        vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0}); // ptr wraps to 0
        vecs.push_back('{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0}); // round-robin
        vecs.push_back('{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0});
        vecs.push_back('{4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0});
        vecs.push_back('{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0});
        vecs.push_back('{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0});
        vecs.push_back('{4'b1111, 4'b0010, 4'b0000, 2'd0, 1'b0});
        vecs.push_back('{4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0});
        vecs.push_back('{4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0});
        vecs.push_back('{4'b1111, 4'b0100, 4'b0000, 2'd0, 1'b0});
        vecs.push_back('{4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0});
        vecs.push_back('{4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0});
        vecs.push_back('{4'b1111, 4'b1000, 4'b0000, 2'd0, 1'b0});
        vecs.push_back('{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0});
        vecs.push_back('{4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0}); // ptr 1
        vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0});

        rst  = 1'b1;
        req  = '0;
        done = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].tmo);
        end

        // Asynchronous reset in the middle of a grant, then arbitration restarts at 0.
        req  = 4'b0100;
        done = '0;
        @(posedge clk);
        #1;
        chk_out("pre_rst", 4'b0100, 2'd2, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_out("mid_rst", 4'b0000, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'b1111;
        @(posedge clk);
        #1;
        chk_out("post_rst", 4'b0001, 2'd0, 1'b0);
        done = 4'b0001;
        @(posedge clk);
        #1;
        chk_out("post_rst_rel", 4'b0000, 2'd0, 1'b0);

        // Long grant on requester 0 with requester 1 waiting.
        done = '0;
        req  = 4'b0001;
        @(posedge clk);
        #1;
        chk_out("long_start", 4'b0001, 2'd0, 1'b0);
        req    = 4'b0011;
        hi     = 1;
        tcount = 0;
        for (int c = 0; c < 120; c++) begin
            @(posedge clk);
            #1;
            if (timeout) tcount++;
            if (gnt == 4'b0001) hi++;
            else break;
        end
`ifdef ARB_TIMEOUT_EN
        chk("tmo_len", 8'(hi), 8'd16);
        chk_out("tmo_drop", 4'b0000, 2'd0, 1'b1);
        @(posedge clk);
        #1;
        chk_out("tmo_next", 4'b0010, 2'd1, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        chk_out("tmo_hold15", 4'b0010, 2'd1, 1'b0);
        done = 4'b0010;
        @(posedge clk);
        #1;
        chk_out("rel_at_tmo", 4'b0000, 2'd0, 1'b0);
`else
        chk("notmo_len", 8'(hi), 8'd121);
        chk("notmo_pulses", 8'(tcount), 8'd0);
        chk_out("notmo_hold", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        @(posedge clk);
        #1;
        chk_out("notmo_drop", 4'b0000, 2'd0, 1'b0);
`endif
        done = '0;
        req  = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
